bulls_and_cows_gen: RTL

BULLS_AND_COWS_GEN -- requirements
Module: bulls_and_cows_gen

---
 rtl/bulls_and_cows_gen.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bulls_and_cows_gen.sv
// Bulls-and-cows scorer: streams a guess one digit per accepted cycle, then scores one position per cycle.
// Optional macro BNC_DUP_CHECK_EN rejects guesses that contain a repeated digit.
module bulls_and_cows_gen #(
    parameter int DIGITS    = 4,
    parameter int DW        = 4,
    parameter int MAX_TRIES = 8,
    localparam int CW       = $clog2(DIGITS + 1),
    localparam int TW       = $clog2(MAX_TRIES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_secret,
    input  logic [DIGITS*DW-1:0] secret_in,
    input  logic [DW-1:0]        number_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CW-1:0]        bulls,
    output logic [CW-1:0]        cows,
    output logic                 valid,
    output logic                 win,
    output logic                 lose,
    output logic [TW-1:0]        tries,
    output logic                 invalid_guess
);

    typedef enum logic [1:0] {IDLE, COLLECT, SCORE, DONE} state_e;

    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST      = IW'(DIGITS - 1);
    localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);
    localparam logic [CW-1:0] ALL_BULLS = CW'(DIGITS);

    state_e                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [DIGITS-1:0][DW-1:0] secret_q, secret_d, guess_q, guess_d;
    logic [CW-1:0]             accBulls_q, accBulls_d, accCows_q, accCows_d;
    logic                      accDup_q, accDup_d;
    logic [CW-1:0]             bulls_q, bulls_d, cows_q, cows_d;
    logic [TW-1:0]             tries_q, tries_d;
    logic                      win_q, win_d, lose_q, lose_d;
    logic                      valid_q, valid_d, invalid_q, invalid_d;

    logic          isBull, isCow, isDup, newDup;
    logic [CW-1:0] newBulls, newCows;
    logic [TW-1:0] triesInc;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        secret_d   = secret_q;
        guess_d    = guess_q;
        accBulls_d = accBulls_q;
        accCows_d  = accCows_q;
        accDup_d   = accDup_q;
        bulls_d    = bulls_q;
        cows_d     = cows_q;
        tries_d    = tries_q;
        win_d      = win_q;
        lose_d     = lose_q;
        valid_d    = 1'b0;
        invalid_d  = 1'b0;

        // A non-bull position earns a cow if its digit sits anywhere else in the secret.
        isBull = (guess_q[idx_q] == secret_q[idx_q]);
        isCow  = 1'b0;
        for (int j = 0; j < DIGITS; j++)
            if (IW'(j) != idx_q && guess_q[idx_q] == secret_q[j]) isCow = 1'b1;
        isDup = 1'b0;
`ifdef BNC_DUP_CHECK_EN
        for (int j = 0; j < DIGITS; j++)
            if (IW'(j) > idx_q && guess_q[j] == guess_q[idx_q]) isDup = 1'b1;
`endif
        newBulls = accBulls_q + CW'(isBull);
        newCows  = accCows_q + CW'(!isBull && isCow);
        newDup   = accDup_q | isDup;
        triesInc = (tries_q == TRIES_MAX) ? tries_q : tries_q + 1'b1;

        unique case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    guess_d[idx_q] = number_in;
                    if (idx_q == LAST) begin
                        idx_d      = '0;
                        accBulls_d = '0;
                        accCows_d  = '0;
                        accDup_d   = 1'b0;
                        state_d    = SCORE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SCORE: begin
                accBulls_d = newBulls;
                accCows_d  = newCows;
                accDup_d   = newDup;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    valid_d = 1'b1;
                    if (newDup) begin
                        invalid_d = 1'b1;
                        bulls_d   = '0;
                        cows_d    = '0;
                        state_d   = COLLECT;
                    end else begin
                        bulls_d = newBulls;
                        cows_d  = newCows;
                        tries_d = triesInc;
                        if (newBulls == ALL_BULLS) begin
                            win_d   = 1'b1;
                            state_d = DONE;
                        end else if (triesInc == TRIES_MAX) begin
                            lose_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase

        // A new secret wins over anything else happening this cycle, including a pending result.
        if (load_secret) begin
            secret_d  = secret_in;
            idx_d     = '0;
            bulls_d   = '0;
            cows_d    = '0;
            tries_d   = '0;
            win_d     = 1'b0;
            lose_d    = 1'b0;
            valid_d   = 1'b0;
            invalid_d = 1'b0;
            state_d   = COLLECT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            secret_q   <= '0;
            guess_q    <= '0;
            accBulls_q <= '0;
            accCows_q  <= '0;
            accDup_q   <= 1'b0;
            bulls_q    <= '0;
            cows_q     <= '0;
            tries_q    <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            valid_q    <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            secret_q   <= secret_d;
            guess_q    <= guess_d;
            accBulls_q <= accBulls_d;
            accCows_q  <= accCows_d;
            accDup_q   <= accDup_d;
            bulls_q    <= bulls_d;
            cows_q     <= cows_d;
            tries_q    <= tries_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            valid_q    <= valid_d;
            invalid_q  <= invalid_d;
        end
    end

    assign in_ready      = (state_q == COLLECT);
    assign bulls         = bulls_q;
    assign cows          = cows_q;
    assign valid         = valid_q;
    assign win           = win_q;
    assign lose          = lose_q;
    assign tries         = tries_q;
    assign invalid_guess = invalid_q;

endmodule
